// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: steps the PC, resolves taken
// branches through a one-cycle LUT lookup, and provides start/stall/halt control.
module pc_sequencer #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0,
    parameter int RELATIVE = 1,
    parameter int CT_W     = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            BranchEn,
    input  logic            Taken,
    input  logic [2:0]      BrIdx,
    output logic [2:0]      LutAddr,
    input  logic [PC_W-1:0] LutTarget,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Fetch,
    output logic            Done,
    output logic [CT_W-1:0] CycleCt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_BR_WAIT = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CT_W-1:0] CT_ONE     = {{(CT_W-1){1'b0}}, 1'b1};
    localparam logic [CT_W-1:0] CT_ZERO    = {CT_W{1'b0}};
    localparam logic [CT_W-1:0] CT_MAX     = {CT_W{1'b1}};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      lut_q, lut_d;
    logic [CT_W-1:0] ct_q, ct_d;
    logic [CT_W-1:0] ct_sat_s;
    logic            fetch_q, done_q;

    assign ct_sat_s = (ct_q == CT_MAX) ? ct_q : (ct_q + CT_ONE);

    // Next-state logic; every register holds unless its state says otherwise.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lut_d   = lut_q;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = START_PC_V;
                    ct_d    = CT_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                ct_d = ct_sat_s;
                if (Halt) begin
                    state_d = S_HALT;
                end else if (Stall) begin
                    state_d = S_RUN;
                end else if (BranchEn && Taken) begin
                    lut_d   = BrIdx;
                    state_d = S_BR_WAIT;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            S_BR_WAIT: begin
                // The branch always completes; control inputs are not sampled here.
                ct_d    = ct_sat_s;
                state_d = S_RUN;
                if (RELATIVE != 0) begin
                    pc_d = pc_q + LutTarget;
                end else begin
                    pc_d = LutTarget;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; Fetch/Done are decoded from the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC_V;
            lut_q   <= 3'd0;
            ct_q    <= CT_ZERO;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lut_q   <= lut_d;
            ct_q    <= ct_d;
            fetch_q <= (state_d == S_RUN);
            done_q  <= (state_d == S_HALT);
        end
    end

    assign LutAddr = lut_q;
    assign ProgCtr = pc_q;
    assign Fetch   = fetch_q;
    assign Done    = done_q;
    assign CycleCt = ct_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a relative-mode instance with the default parameters
// and an absolute-mode instance with START_PC=5 and a 4-bit saturating counter.
module tb_pc_sequencer;

    typedef struct {
        logic        which;      // 0: relative instance, 1: absolute instance
        logic        rst, start, stall, halt, br_en, taken;
        logic [2:0]  idx;
        logic [9:0]  pc;
        logic        fetch, done;
        logic [2:0]  lut;
        logic [15:0] ct;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, stall, halt, br_en, taken;
    logic [2:0]  br_idx;
    logic [2:0]  lut_addr, lut_addr_a;
    logic [9:0]  lut_tgt, lut_tgt_a, prog_ctr, prog_ctr_a;
    logic        fetch, done, fetch_a, done_a;
    logic [15:0] cycle_ct;
    logic [3:0]  cycle_ct_a;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [9:0] lut_f(input logic [2:0] a);
        case (a)
            3'd0:    lut_f = 10'h3F0;
            3'd1:    lut_f = 10'h003;
            3'd2:    lut_f = 10'h007;
            default: lut_f = 10'h001;
        endcase
    endfunction

    assign lut_tgt   = lut_f(lut_addr);
    assign lut_tgt_a = lut_f(lut_addr_a);

    pc_sequencer u_rel (
        .Clk(clk), .Reset(reset), .Start(start), .Stall(stall), .Halt(halt),
        .BranchEn(br_en), .Taken(taken), .BrIdx(br_idx), .LutAddr(lut_addr),
        .LutTarget(lut_tgt), .ProgCtr(prog_ctr), .Fetch(fetch), .Done(done),
        .CycleCt(cycle_ct)
    );

    pc_sequencer #(.PC_W(10), .START_PC(5), .RELATIVE(0), .CT_W(4)) u_abs (
        .Clk(clk), .Reset(reset), .Start(start), .Stall(stall), .Halt(halt),
        .BranchEn(br_en), .Taken(taken), .BrIdx(br_idx), .LutAddr(lut_addr_a),
        .LutTarget(lut_tgt_a), .ProgCtr(prog_ctr_a), .Fetch(fetch_a), .Done(done_a),
        .CycleCt(cycle_ct_a)
    );

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0d want %0d", name, step, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic s, input logic st,
                       input logic h, input logic b, input logic t, input logic [2:0] ix,
                       input int pc, input logic f, input logic d, input logic [2:0] l,
                       input int ct);
        vec_t v;
        v.which = w; v.rst = r; v.start = s; v.stall = st; v.halt = h;
        v.br_en = b; v.taken = t; v.idx = ix;
        v.pc = pc[9:0]; v.fetch = f; v.done = d; v.lut = l; v.ct = ct[15:0];
        tbl.push_back(v);
    endtask

    // Drive one vector, queue its expectation, and check it after the edge.
    task automatic apply(input vec_t v, input int step);
        vec_t e;
        reset = v.rst; start = v.start; stall = v.stall; halt = v.halt;
        br_en = v.br_en; taken = v.taken; br_idx = v.idx;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.which == 1'b0) begin
            chk("pc", step, 32'(prog_ctr), 32'(e.pc));
            chk("fetch", step, 32'(fetch), 32'(e.fetch));
            chk("done", step, 32'(done), 32'(e.done));
            chk("lutaddr", step, 32'(lut_addr), 32'(e.lut));
            chk("cyclect", step, 32'(cycle_ct), 32'(e.ct));
        end else begin
            chk("abs_pc", step, 32'(prog_ctr_a), 32'(e.pc));
            chk("abs_fetch", step, 32'(fetch_a), 32'(e.fetch));
            chk("abs_done", step, 32'(done_a), 32'(e.done));
            chk("abs_lutaddr", step, 32'(lut_addr_a), 32'(e.lut));
            chk("abs_cyclect", step, 32'(cycle_ct_a), 32'(e.ct));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
        br_en = 1'b0; taken = 1'b0; br_idx = 3'd0;

        // w  rst st stl hlt br tk idx   pc   f  d  lut  ct
        add(0, 1, 0, 0, 0, 0, 0, 3'd0,   0,   0, 0, 3'd0, 0);
        add(0, 0, 0, 1, 1, 1, 1, 3'd5,   0,   0, 0, 3'd0, 0);   // IDLE ignores all but Start
        add(0, 0, 1, 0, 0, 0, 0, 3'd0,   0,   1, 0, 3'd0, 0);
        for (int i = 1; i <= 20; i++) add(0, 0, 0, 0, 0, 0, 0, 3'd0, i, 1, 0, 3'd0, i);
        add(0, 0, 0, 0, 0, 1, 1, 3'd0,  20,   0, 0, 3'd0, 21);  // taken, offset -16
        add(0, 0, 1, 1, 1, 1, 1, 3'd6,   4,   1, 0, 3'd0, 22);  // BR_WAIT ignores controls
        for (int i = 5; i <= 20; i++) add(0, 0, 0, 0, 0, 0, 0, 3'd0, i, 1, 0, 3'd0, 22 + i - 4);
        add(0, 0, 0, 0, 0, 1, 1, 3'd1,  20,   0, 0, 3'd1, 39);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,  23,   1, 0, 3'd1, 40);
        add(0, 0, 0, 0, 0, 1, 1, 3'd0,  23,   0, 0, 3'd0, 41);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,   7,   1, 0, 3'd0, 42);
        for (int i = 8; i <= 20; i++) add(0, 0, 0, 0, 0, 0, 0, 3'd0, i, 1, 0, 3'd0, 42 + i - 7);
        add(0, 0, 0, 0, 0, 1, 1, 3'd3,  20,   0, 0, 3'd3, 56);  // default LUT entry
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,  21,   1, 0, 3'd3, 57);
        add(0, 0, 0, 0, 0, 1, 0, 3'd2,  22,   1, 0, 3'd3, 58);  // not taken: no bubble
        for (int i = 23; i <= 1020; i++) add(0, 0, 0, 0, 0, 0, 0, 3'd0, i, 1, 0, 3'd3, 58 + i - 22);
        add(0, 0, 0, 0, 0, 1, 1, 3'd2, 1020,  0, 0, 3'd2, 1057);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,   3,   1, 0, 3'd2, 1058); // target wraps
        for (int i = 4; i <= 1023; i++) add(0, 0, 0, 0, 0, 0, 0, 3'd0, i, 1, 0, 3'd2, 1058 + i - 3);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,   0,   1, 0, 3'd2, 2079); // 1023 -> 0
        for (int i = 1; i <= 9; i++) add(0, 0, 0, 0, 0, 0, 0, 3'd0, i, 1, 0, 3'd2, 2079 + i);
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 1, 0, 0, 0, 3'd0, 9, 1, 0, 3'd2, 2088 + i);
        add(0, 0, 0, 1, 0, 1, 1, 3'd1,   9,   1, 0, 3'd2, 2092); // stall beats branch
        add(0, 0, 0, 0, 0, 1, 1, 3'd1,   9,   0, 0, 3'd1, 2093);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,  12,   1, 0, 3'd1, 2094);
        add(0, 0, 0, 0, 1, 1, 1, 3'd4,  12,   0, 1, 3'd1, 2095); // halt beats branch
        add(0, 0, 0, 1, 0, 1, 1, 3'd5,  12,   0, 1, 3'd1, 2095);
        add(0, 0, 1, 0, 0, 0, 0, 3'd0,   0,   1, 0, 3'd1, 0);    // restart from HALT
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,   1,   1, 0, 3'd1, 1);
        add(0, 0, 0, 0, 0, 1, 1, 3'd0,   1,   0, 0, 3'd0, 2);
        add(0, 1, 0, 0, 0, 0, 0, 3'd0,   0,   0, 0, 3'd0, 0);    // reset in BR_WAIT
        add(0, 0, 0, 0, 0, 0, 0, 3'd0,   0,   0, 0, 3'd0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 3'd0,   0,   1, 0, 3'd0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 3'd0,   1,   1, 0, 3'd0, 1);    // Start in RUN ignored

        // Absolute mode, START_PC=5, 4-bit counter saturating at 15.
        add(1, 1, 0, 0, 0, 0, 0, 3'd0,   5,   0, 0, 3'd0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 3'd0,   5,   1, 0, 3'd0, 0);
        for (int i = 1; i <= 20; i++) add(1, 0, 0, 0, 0, 0, 0, 3'd0, 5 + i, 1, 0, 3'd0, (i > 15) ? 15 : i);
        add(1, 0, 0, 0, 0, 1, 1, 3'd2,  25,   0, 0, 3'd2, 15);
        add(1, 0, 0, 0, 0, 0, 0, 3'd0,   7,   1, 0, 3'd2, 15);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the processor fetch stage.
- Holds the 10-bit PC, steps it each cycle, and services taken branches by driving the 3-bit branch-target LUT index.
- Applies the returned 10-bit target as a PC-relative offset (or as an absolute address).
- Also provides start/stall/halt control and a run-cycle counter for the test harness.

Parameters:
- PC_W, 10, PC and LUT target width.
- START_PC, 0, PC value loaded on Reset and on Start.
- RELATIVE, 1, 1: new PC = PC + LutTarget (mod 2^PC_W); 0: new PC = LutTarget.
- CT_W, 16, width of the cycle counter.

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high; overrides all other inputs.
- Start, input, 1, begin or restart execution at START_PC (honoured in IDLE and HALT only).
- Stall, input, 1, hold the PC for this cycle (RUN only).
- Halt, input, 1, decoded halt instruction at the current PC.
- BranchEn, input, 1, current instruction is a branch.
- Taken, input, 1, branch condition true (qualified by BranchEn).
- BrIdx, input, 3, LUT index supplied by the branch instruction.
- LutAddr, output, 3, registered index driven to the target LUT.
- LutTarget, input, PC_W, target/offset returned by the LUT (combinational from LutAddr).
- ProgCtr, output, PC_W, current PC (registered).
- Fetch, output, 1, instruction at ProgCtr is valid this cycle.
- Done, output, 1, processor halted.
- CycleCt, output, CT_W, cycles spent in RUN + BR_WAIT.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Clock and reset ports are named Clk and Reset.
- Reset values: state=IDLE, ProgCtr=START_PC, LutAddr=0, CycleCt=0. Outputs Fetch=0 and Done=0.
- Moore outputs: Fetch = (state==RUN); Done = (state==HALT).
- IDLE:
  - Start → RUN, ProgCtr=START_PC, CycleCt=0.
  - Other inputs are ignored.
- RUN: per-cycle priority is Halt > Stall > (BranchEn & Taken) > increment.
  - Halt: → HALT; ProgCtr holds at the halt instruction.
  - Stall: ProgCtr holds; state stays RUN; CycleCt still counts.
  - BranchEn & Taken: LutAddr <= BrIdx; → BR_WAIT; ProgCtr holds.
  - BranchEn & !Taken, or no branch: ProgCtr <= ProgCtr+1, wrapping 1023→0.
- BR_WAIT (exactly one cycle, a fetch bubble with Fetch=0):
  - RELATIVE=1: ProgCtr <= ProgCtr + LutTarget, truncated to PC_W bits (two's-complement offsets work by wrap; 0x3F0 = −16).
  - RELATIVE=0: ProgCtr <= LutTarget.
  - Then → RUN.
  - Stall, Halt, BranchEn and Start are ignored in this state; the branch always completes.
- HALT:
  - ProgCtr and CycleCt frozen.
  - Start → RUN with ProgCtr=START_PC, CycleCt=0.
- Latency:
  - Not-taken or sequential instruction: 1 cycle per instruction.
  - Taken branch: 2 cycles (branch cycle + BR_WAIT); the first target fetch is on the cycle after BR_WAIT.
- CycleCt: increments every cycle in RUN or BR_WAIT and saturates at 2^CT_W−1 (no wrap).
- LutAddr: changes only on a taken-branch capture or Reset; otherwise it holds its last value.
- Reset mid-operation (any state, including BR_WAIT): next cycle is IDLE with all reset values; the pending branch is discarded.
- Simultaneous events:
  - Halt + taken branch in the same RUN cycle → Halt wins; LutAddr unchanged.
  - Stall + taken branch → Stall wins; the branch is re-evaluated the next cycle.
  - Start asserted during RUN has no effect.

Test Plan:
- Reset then Start, no other inputs for 5 cycles → ProgCtr 0,1,2,3,4; Fetch=1 throughout; CycleCt=5 after the 5th cycle.
- At PC=20, BranchEn=1, Taken=1, BrIdx=000 (LUT 0x3F0) → cycle+1: LutAddr=0, ProgCtr=20, Fetch=0; cycle+2: ProgCtr=4, Fetch=1.
- Taken branches with BrIdx=001 (LUT 0x003) and BrIdx=011 (LUT default 0x001) at PC=20 → ProgCtr 23 and 21 respectively. BranchEn=1 with Taken=0 at PC=20 → ProgCtr 21 with no bubble.
- PC=1023 with no branch → ProgCtr=0. PC=1020 with taken branch to target 0x007 → ProgCtr=3 (wrap).
- Stall held 3 cycles at PC=9 → ProgCtr stays 9 and CycleCt advances by 3. Stall+taken branch together, then Stall drops → branch taken one cycle later. Halt+taken branch together → Done=1 next cycle, ProgCtr frozen, LutAddr unchanged.
- Reset asserted during BR_WAIT → next cycle state IDLE, ProgCtr=0, Fetch=0, LutAddr=0. Start from HALT → ProgCtr=0, CycleCt=0, Done=0.
